reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/core_pkg.sv | 25 ++
 rtl/reg_scoreboard_sb_counter.sv | 54 +++++
 rtl/reg_scoreboard.sv | 134 +++++++++++++
 tb/tb_reg_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register-index type, GPR index constants and
// scoreboard sizing defaults.
package core_pkg;

    localparam int NREGS_DEF = 32;
    localparam int CNT_W_DEF = 2;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t GPR_RAX = 5'd0;
    localparam reg_idx_t GPR_RCX = 5'd1;
    localparam reg_idx_t GPR_RDX = 5'd2;
    localparam reg_idx_t GPR_RBX = 5'd3;
    localparam reg_idx_t GPR_RSP = 5'd4;
    localparam reg_idx_t GPR_RBP = 5'd5;
    localparam reg_idx_t GPR_RSI = 5'd6;
    localparam reg_idx_t GPR_RDI = 5'd7;

    // An index selects a slot only when it names that exact tracked register;
    // indices beyond the tracked range therefore never match any slot.
    function automatic logic idx_match(input reg_idx_t idx, input int slot);
        return (int'(idx) == slot);
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down count with
// synchronous clear and a registered nonzero flag.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             nonzero
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             nonzero_r;
    logic             inc_ok_s;
    logic             dec_ok_s;

    assign inc_ok_s = inc && (count_r != CNT_MAX);
    assign dec_ok_s = dec && (count_r != {CNT_W{1'b0}});

    // Next count: clear wins, an increment and decrement together cancel.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            case ({inc_ok_s, dec_ok_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Count and its nonzero flag update together so busy tracks the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r   <= {CNT_W{1'b0}};
            nonzero_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            nonzero_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    assign count   = count_r;
    assign nonzero = nonzero_r;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per architectural register and
// gates issue on RAW hazards and WAW counter saturation.
// Optional issue-stall statistics enabled by REG_SCOREBOARD_STATS_EN.
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [2:0]       iss_src_valid,
    input  logic [4:0]       iss_src0,
    input  logic [4:0]       iss_src1,
    input  logic [4:0]       iss_src2,
    input  logic             iss_dst_valid,
    input  logic [4:0]       iss_dst,
    input  logic             wb_valid,
    input  logic [4:0]       wb_reg,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             idle,
    output logic             err_underflow,
    output logic [31:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_s [NREGS];
    logic [NREGS-1:0] nonzero_s;
    logic [NREGS-1:0] inc_s;
    logic [NREGS-1:0] dec_s;
    logic             src_hit_s;
    logic             dst_full_s;
    logic             ready_s;
    logic             fire_s;
    logic             underflow_s;
    logic             err_r;

    // Hazard lookup against registered counters only; writeback never bypasses.
    always_comb begin
        src_hit_s  = 1'b0;
        dst_full_s = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (nonzero_s[i] &&
                ((iss_src_valid[0] && idx_match(iss_src0, i)) ||
                 (iss_src_valid[1] && idx_match(iss_src1, i)) ||
                 (iss_src_valid[2] && idx_match(iss_src2, i)))) begin
                src_hit_s = 1'b1;
            end else begin
                src_hit_s = src_hit_s;
            end
            if (iss_dst_valid && idx_match(iss_dst, i) && (count_s[i] == CNT_MAX)) begin
                dst_full_s = 1'b1;
            end else begin
                dst_full_s = dst_full_s;
            end
        end
    end

    // Issue gate, held low in reset and during a flush.
    always_comb begin
        ready_s = 1'b0;
        if (!reset_n || flush) begin
            ready_s = 1'b0;
        end else begin
            ready_s = !src_hit_s && !dst_full_s;
        end
    end

    assign fire_s = iss_valid && ready_s;

    // One-hot increment/decrement strobes per tracked register.
    always_comb begin
        inc_s = {NREGS{1'b0}};
        dec_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            inc_s[i] = fire_s && iss_dst_valid && idx_match(iss_dst, i);
            dec_s[i] = wb_valid && idx_match(wb_reg, i);
        end
    end

    assign underflow_s = |(dec_s & ~nonzero_s);

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (inc_s[g]),
            .dec     (dec_s[g]),
            .clr     (flush),
            .count   (count_s[g]),
            .nonzero (nonzero_s[g])
        );
    end

    // Sticky underflow flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (underflow_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign iss_ready     = ready_s;
    assign busy          = nonzero_s;
    assign idle          = ~|nonzero_s;
    assign err_underflow = err_r;

`ifdef REG_SCOREBOARD_STATS_EN
    logic [31:0] stall_r;

    // Saturating count of cycles where a valid micro-op was held back.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_r <= 32'd0;
        end else if (iss_valid && !ready_s && !flush && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cycles = stall_r;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: expectations are queued as
// stimulus is driven and compared when the DUT outputs are sampled.
module tb_reg_scoreboard;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iss_valid;
    logic        iss_ready;
    logic [2:0]  iss_src_valid;
    logic [4:0]  iss_src0, iss_src1, iss_src2;
    logic        iss_dst_valid;
    logic [4:0]  iss_dst;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        flush;
    logic [31:0] busy;
    logic        idle;
    logic        err_underflow;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    int mcnt [32];
    bit merr;
    int mstall;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];

    localparam int K_READY = 0, K_BUSYBIT = 1, K_BUSY = 2, K_IDLE = 3, K_ERR = 4, K_STALL = 5;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREGS(32), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src_valid(iss_src_valid), .iss_src0(iss_src0), .iss_src1(iss_src1),
        .iss_src2(iss_src2), .iss_dst_valid(iss_dst_valid), .iss_dst(iss_dst),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .busy(busy), .idle(idle),
        .err_underflow(err_underflow), .stall_cycles(stall_cycles)
    );

    function automatic string kname(input int k);
        case (k)
            K_READY:   return "iss_ready";
            K_BUSYBIT: return "busy_bit";
            K_BUSY:    return "busy";
            K_IDLE:    return "idle";
            K_ERR:     return "err_underflow";
            K_STALL:   return "stall_cycles";
            default:   return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] observe(input int k, input int idx);
        case (k)
            K_READY:   return {31'd0, iss_ready};
            K_BUSYBIT: return {31'd0, busy[idx]};
            K_BUSY:    return busy;
            K_IDLE:    return {31'd0, idle};
            K_ERR:     return {31'd0, err_underflow};
            K_STALL:   return stall_cycles;
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit m_ready();
        if (!reset_n || flush) return 1'b0;
        if (iss_src_valid[0] && mcnt[iss_src0] != 0) return 1'b0;
        if (iss_src_valid[1] && mcnt[iss_src1] != 0) return 1'b0;
        if (iss_src_valid[2] && mcnt[iss_src2] != 0) return 1'b0;
        if (iss_dst_valid && mcnt[iss_dst] == 3) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = 32'd0;
        for (int i = 0; i < 32; i++) b[i] = (mcnt[i] != 0);
        return b;
    endfunction

    task automatic push(input int k, input int idx, input logic [31:0] v);
        exp_t e;
        e.kind = k; e.idx = idx; e.val = v;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.kind, e.idx);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s idx=%0d observed=%0h expected=%0h", kname(e.kind), e.idx, obs, e.val);
            end
        end
    endtask

    task automatic quiet();
        iss_valid = 1'b0; iss_src_valid = 3'b000; iss_dst_valid = 1'b0;
        iss_src0 = 5'd0; iss_src1 = 5'd0; iss_src2 = 5'd0; iss_dst = 5'd0;
        wb_valid = 1'b0; wb_reg = 5'd0; flush = 1'b0;
    endtask

    // One clock: check combinational ready, advance model and DUT, check state.
    task automatic tick();
        bit r, fire, uf, st, inc, dec;
        #1;
        r = m_ready();
        push(K_READY, 0, {31'd0, r});
        drain();
        fire = iss_valid && r;
        uf   = wb_valid && (mcnt[wb_reg] == 0);
        st   = iss_valid && !r && !flush;
        inc  = fire && iss_dst_valid;
        dec  = wb_valid && (mcnt[wb_reg] != 0);
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
            merr = 1'b0; mstall = 0;
        end else begin
            if (flush) begin
                for (int i = 0; i < 32; i++) mcnt[i] = 0;
            end else if (!(inc && dec && iss_dst == wb_reg)) begin
                if (inc) mcnt[iss_dst] = mcnt[iss_dst] + 1;
                if (dec) mcnt[wb_reg] = mcnt[wb_reg] - 1;
            end
            if (uf) merr = 1'b1;
`ifdef REG_SCOREBOARD_STATS_EN
            if (st) mstall = mstall + 1;
`endif
        end
        #1;
        push(K_BUSY, 0, m_busy());
        push(K_IDLE, 0, {31'd0, (m_busy() == 32'd0)});
        push(K_ERR, 0, {31'd0, merr});
        push(K_STALL, 0, mstall);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        merr = 1'b0; mstall = 0;
        quiet();

        // Reset held two cycles with a pending micro-op presented.
        reset_n = 1'b0; iss_valid = 1'b1;
        push(K_READY, 0, 32'd0); tick();
        push(K_READY, 0, 32'd0); tick();
        push(K_IDLE, 0, 32'd1); push(K_BUSY, 0, 32'd0); push(K_ERR, 0, 32'd0); drain();
        reset_n = 1'b1;
        push(K_READY, 0, 32'd1); tick();

        // RAW on RAX.
        quiet(); iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst = GPR_RAX; tick();
        quiet(); iss_valid = 1'b1; iss_src_valid = 3'b001; iss_src0 = GPR_RAX;
        push(K_READY, 0, 32'd0); tick();
        wb_valid = 1'b1; wb_reg = GPR_RAX;
        push(K_READY, 0, 32'd0); tick();
        wb_valid = 1'b0;
        push(K_READY, 0, 32'd1); tick();

        // WAW saturation on RBX.
        quiet(); iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst = GPR_RBX;
        tick(); tick(); tick();
        push(K_BUSYBIT, 3, 32'd1); drain();
        push(K_READY, 0, 32'd0); tick();
        wb_valid = 1'b1; wb_reg = GPR_RBX;
        push(K_READY, 0, 32'd0); tick();
        wb_valid = 1'b0;
        push(K_READY, 0, 32'd1); tick();
        quiet(); wb_valid = 1'b1; wb_reg = GPR_RBX; tick(); tick(); tick();
        push(K_BUSYBIT, 3, 32'd0); drain();

        // Simultaneous issue and writeback on RBP.
        quiet(); iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst = GPR_RBP; tick();
        wb_valid = 1'b1; wb_reg = GPR_RBP; tick();
        push(K_BUSYBIT, 5, 32'd1); drain();
        quiet(); wb_valid = 1'b1; wb_reg = GPR_RBP; tick();
        push(K_BUSYBIT, 5, 32'd0); push(K_ERR, 0, 32'd0); drain();

        // Flush overrides a same-cycle issue.
        quiet(); iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst = GPR_RCX; tick(); tick();
        iss_dst = GPR_RDI; tick();
        push(K_IDLE, 0, 32'd0); drain();
        quiet(); flush = 1'b1; iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst = GPR_RDX;
        push(K_READY, 0, 32'd0); tick();
        push(K_IDLE, 0, 32'd1); push(K_BUSY, 0, 32'd0); drain();

        // Underflow is sticky.
        quiet(); wb_valid = 1'b1; wb_reg = 5'd9; tick();
        push(K_ERR, 0, 32'd1); drain();
        quiet(); tick();
        push(K_ERR, 0, 32'd1); drain();

        // Mid-operation reset discards pending state and clears the flag.
        quiet(); iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst = GPR_RSP; tick();
        quiet(); reset_n = 1'b0; tick();
        reset_n = 1'b1;
        push(K_IDLE, 0, 32'd1); push(K_ERR, 0, 32'd0); push(K_STALL, 0, 32'd0); drain();

        // Four stalled cycles on a RAW against RSP.
        quiet(); iss_valid = 1'b1; iss_dst_valid = 1'b1; iss_dst = GPR_RSP; tick();
        quiet(); iss_valid = 1'b1; iss_src_valid = 3'b100; iss_src2 = GPR_RSP;
        tick(); tick(); tick(); tick();
`ifdef REG_SCOREBOARD_STATS_EN
        push(K_STALL, 0, 32'd4);
`else
        push(K_STALL, 0, 32'd0);
`endif
        drain();
        quiet(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
